// File: rtl/seq_pattern_checker.sv
// seq_pattern_checker
//   Serial receiver and frame checker for the 12-state sequence generator.
//   Synchronises the incoming line and re-aligns bit timing on every line
//   edge. Each bit is sampled at mid-bit. The checker then finds 12-bit frame
//   alignment against PATTERN, tracks lock, and counts good frames.
//
// Ports
//   iCLK     in   system clock, rising edge
//   iRST     in   synchronous active-high reset
//   iSIG     in   serial line (asynchronous)
//   oBIT     out  last recovered bit
//   oBSTB    out  one-cycle pulse when oBIT updates
//   oLOCK    out  frame alignment locked
//   oMATCH   out  one-cycle pulse, frame compare matched
//   oERR     out  one-cycle pulse, frame compare failed while locked
//   oFRAMES  out  good frames counted while locked, saturating at 255
//
// state  | meaning
// -------+-------------------------------------------------------------
// SEARCH | sliding compare on every strobe, looking for frame alignment
// VERIFY | aligned candidate, confirming on frame boundaries
// LOCKED | locked; matches counted, LOSS_N consecutive misses drop lock
module seq_pattern_checker #(
  parameter int          BIT_CLKS = 500000,
  parameter logic [11:0] PATTERN  = 12'b000100010110,
  parameter int          LOCK_N   = 2,
  parameter int          LOSS_N   = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSIG,
  output logic       oBIT,
  output logic       oBSTB,
  output logic       oLOCK,
  output logic       oMATCH,
  output logic       oERR,
  output logic [7:0] oFRAMES
);

  localparam int PW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(BIT_CLKS - 1);
  localparam logic [PW-1:0] PHASE_MID = PW'(BIT_CLKS / 2 - 1);
  localparam int CNT_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} stateT;

  stateT          state;
  logic           syncQ1;
  logic           sigS;
  logic           sigPrev;
  logic [PW-1:0]  phase;
  logic [11:0]    shiftReg;
  logic [3:0]     fill;
  logic [3:0]     bitCnt;
  logic [CW-1:0]  goodCnt;
  logic [CW-1:0]  badCnt;

  logic           edgeDet;
  logic           strobe;
  logic [11:0]    srNext;
  logic [3:0]     fillNext;
  logic           srMatch;
  logic           frameEnd;

  // An edge reloads the phase counter and suppresses the strobe that cycle.
  assign edgeDet  = sigS ^ sigPrev;
  assign strobe   = !edgeDet && (phase == PHASE_MID);
  assign srNext   = {shiftReg[10:0], sigS};
  assign fillNext = (fill == 4'd12) ? fill : fill + 4'd1;
  // Compare against the value the shift register takes on this strobe.
  assign srMatch  = (srNext == PATTERN);
  assign frameEnd = (bitCnt == 4'd11);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= SEARCH;
      syncQ1   <= 1'b0;
      sigS     <= 1'b0;
      sigPrev  <= 1'b0;
      phase    <= '0;
      shiftReg <= '0;
      fill     <= '0;
      bitCnt   <= '0;
      goodCnt  <= '0;
      badCnt   <= '0;
      oBIT     <= 1'b0;
      oBSTB    <= 1'b0;
      oLOCK    <= 1'b0;
      oMATCH   <= 1'b0;
      oERR     <= 1'b0;
      oFRAMES  <= '0;
    end else begin
      syncQ1  <= iSIG;
      sigS    <= syncQ1;
      sigPrev <= sigS;
      oBSTB   <= 1'b0;
      oMATCH  <= 1'b0;
      oERR    <= 1'b0;

      if (edgeDet || (phase == PHASE_MAX)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end

      if (strobe) begin
        shiftReg <= srNext;
        fill     <= fillNext;
        oBIT     <= sigS;
        oBSTB    <= 1'b1;
        bitCnt   <= frameEnd ? 4'd0 : bitCnt + 4'd1;

        case (state)
          SEARCH: begin
            if ((fillNext == 4'd12) && srMatch) begin
              oMATCH  <= 1'b1;
              bitCnt  <= 4'd0;
              goodCnt <= CW'(1);
              badCnt  <= '0;
              if (LOCK_N <= 1) begin
                oLOCK <= 1'b1;
                state <= LOCKED;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (frameEnd) begin
              if (srMatch) begin
                oMATCH  <= 1'b1;
                goodCnt <= goodCnt + 1'b1;
                if ((goodCnt + 1'b1) == CW'(LOCK_N)) begin
                  oLOCK  <= 1'b1;
                  badCnt <= '0;
                  state  <= LOCKED;
                end
              end else begin
                goodCnt <= '0;
                state   <= SEARCH;
              end
            end
          end
          LOCKED: begin
            if (frameEnd) begin
              if (srMatch) begin
                oMATCH <= 1'b1;
                badCnt <= '0;
                if (oFRAMES != 8'hFF) begin
                  oFRAMES <= oFRAMES + 8'd1;
                end
              end else begin
                oERR   <= 1'b1;
                badCnt <= badCnt + 1'b1;
                if ((badCnt + 1'b1) == CW'(LOSS_N)) begin
                  // Fill is kept so the search resumes on the very next strobe.
                  oLOCK   <= 1'b0;
                  goodCnt <= '0;
                  badCnt  <= '0;
                  state   <= SEARCH;
                end
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_checker.sv
// tb_seq_pattern_checker
//   Directed bench for seq_pattern_checker with BIT_CLKS=8, driving an ideal
//   generator model (8 clocks per bit, MSB of the frame first).
module tb_seq_pattern_checker;

  localparam int          BIT_CLKS = 8;
  localparam logic [11:0] PAT      = 12'b000100010110;
  localparam logic [11:0] BAD      = PAT ^ 12'h800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic       oBit, oBstb, oLock, oMatch, oErr;
  logic [7:0] oFrames;

  int checks = 0;
  int errors = 0;

  int strobeCnt = 0, matchCnt = 0, errCnt = 0;
  int firstMatchIdx = 0, lockIdx = 0, errLockLow = 0;

  seq_pattern_checker #(
    .BIT_CLKS(BIT_CLKS), .PATTERN(PAT), .LOCK_N(2), .LOSS_N(2)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSIG(sig),
    .oBIT(oBit), .oBSTB(oBstb), .oLOCK(oLock),
    .oMATCH(oMatch), .oERR(oErr), .oFRAMES(oFrames)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge; cleared while reset is held.
  always @(negedge clk) begin
    if (rst) begin
      strobeCnt = 0; matchCnt = 0; errCnt = 0;
      firstMatchIdx = 0; lockIdx = 0; errLockLow = 0;
    end else begin
      if (oBstb) strobeCnt++;
      if (oMatch) begin
        matchCnt++;
        if (firstMatchIdx == 0) firstMatchIdx = strobeCnt;
      end
      if (oErr) begin
        errCnt++;
        if (!oLock) errLockLow++;
      end
      if (oLock && lockIdx == 0) lockIdx = strobeCnt;
    end
  end

  task automatic sendBit(input logic b, input int len);
    sig = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [11:0] f, input int stretch);
    for (int i = 0; i < 12; i++) sendBit(f[11-i], (i == stretch) ? 11 : 8);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b1;
    sig = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oBit !== 1'b0)    begin errors++; $display("FAIL reset_bit got %0b want 0", oBit); end
    checks++; if (oBstb !== 1'b0)   begin errors++; $display("FAIL reset_bstb got %0b want 0", oBstb); end
    checks++; if (oLock !== 1'b0)   begin errors++; $display("FAIL reset_lock got %0b want 0", oLock); end
    checks++; if (oMatch !== 1'b0)  begin errors++; $display("FAIL reset_match got %0b want 0", oMatch); end
    checks++; if (oErr !== 1'b0)    begin errors++; $display("FAIL reset_err got %0b want 0", oErr); end
    checks++; if (oFrames !== 8'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", oFrames); end
    rst = 1'b0;
  endtask

  // Expects to start right after reset release with the line at 0.
  task automatic test_lock_count();
    sendFrame(PAT, -1);
    checks++; if (firstMatchIdx !== 12) begin errors++; $display("FAIL first_match_strobe got %0d want 12", firstMatchIdx); end
    checks++; if (oLock !== 1'b0)       begin errors++; $display("FAIL lock_after_f1 got %0b want 0", oLock); end
    checks++; if (matchCnt !== 1)       begin errors++; $display("FAIL matches_after_f1 got %0d want 1", matchCnt); end
    sendFrame(PAT, -1);
    checks++; if (lockIdx !== 24)       begin errors++; $display("FAIL lock_strobe got %0d want 24", lockIdx); end
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL lock_after_f2 got %0b want 1", oLock); end
    checks++; if (oFrames !== 8'd0)     begin errors++; $display("FAIL frames_after_f2 got %0d want 0", oFrames); end
    sendFrame(PAT, -1);
    checks++; if (oFrames !== 8'd1)     begin errors++; $display("FAIL frames_after_f3 got %0d want 1", oFrames); end
    sendFrame(PAT, -1);
    sendFrame(PAT, -1);
    checks++; if (oFrames !== 8'd3)     begin errors++; $display("FAIL frames_after_f5 got %0d want 3", oFrames); end
    checks++; if (errCnt !== 0)         begin errors++; $display("FAIL errs_clean_stream got %0d want 0", errCnt); end
  endtask

  task automatic test_single_error();
    int e0, m0;
    e0 = errCnt;
    m0 = matchCnt;
    sendFrame(BAD, -1);
    checks++; if (errCnt !== e0 + 1)    begin errors++; $display("FAIL single_err_count got %0d want %0d", errCnt, e0 + 1); end
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL single_err_lock got %0b want 1", oLock); end
    checks++; if (oFrames !== 8'd3)     begin errors++; $display("FAIL single_err_frames got %0d want 3", oFrames); end
    sendFrame(PAT, -1);
    checks++; if (matchCnt !== m0 + 1)  begin errors++; $display("FAIL recover_match got %0d want %0d", matchCnt, m0 + 1); end
    checks++; if (oFrames !== 8'd4)     begin errors++; $display("FAIL recover_frames got %0d want 4", oFrames); end
    sendFrame(BAD, -1);
    checks++; if (errCnt !== e0 + 2)    begin errors++; $display("FAIL second_err_count got %0d want %0d", errCnt, e0 + 2); end
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL second_err_lock got %0b want 1", oLock); end
    sendFrame(PAT, -1);
    checks++; if (oFrames !== 8'd5)     begin errors++; $display("FAIL frames_after_errs got %0d want 5", oFrames); end
  endtask

  task automatic test_loss_of_lock();
    int e0, m0;
    e0 = errCnt;
    sendFrame(BAD, -1);
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL loss_first_err_lock got %0b want 1", oLock); end
    sendFrame(BAD, -1);
    checks++; if (errCnt !== e0 + 2)    begin errors++; $display("FAIL loss_err_count got %0d want %0d", errCnt, e0 + 2); end
    checks++; if (oLock !== 1'b0)       begin errors++; $display("FAIL loss_lock got %0b want 0", oLock); end
    checks++; if (errLockLow !== 1)     begin errors++; $display("FAIL loss_same_cycle got %0d want 1", errLockLow); end
    checks++; if (oFrames !== 8'd5)     begin errors++; $display("FAIL loss_frames_hold got %0d want 5", oFrames); end
    m0 = matchCnt;
    sendFrame(PAT, -1);
    checks++; if (matchCnt !== m0 + 1)  begin errors++; $display("FAIL relock_search_hit got %0d want %0d", matchCnt, m0 + 1); end
    checks++; if (oLock !== 1'b0)       begin errors++; $display("FAIL relock_verify_lock got %0b want 0", oLock); end
    sendFrame(PAT, -1);
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL relock_lock got %0b want 1", oLock); end
    checks++; if (oFrames !== 8'd5)     begin errors++; $display("FAIL relock_frames got %0d want 5", oFrames); end
    sendFrame(PAT, -1);
    checks++; if (oFrames !== 8'd6)     begin errors++; $display("FAIL relock_count got %0d want 6", oFrames); end
  endtask

  task automatic test_phase_drift();
    int e0;
    e0 = errCnt;
    sendFrame(PAT, 3);
    sendFrame(PAT, -1);
    checks++; if (errCnt !== e0)        begin errors++; $display("FAIL drift_errs got %0d want %0d", errCnt, e0); end
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL drift_lock got %0b want 1", oLock); end
    checks++; if (oFrames !== 8'd8)     begin errors++; $display("FAIL drift_frames got %0d want 8", oFrames); end
    checks++; if (oBit !== 1'b0)        begin errors++; $display("FAIL drift_last_bit got %0b want 0", oBit); end
  endtask

  task automatic test_static_line();
    pulseReset();
    repeat (200 * BIT_CLKS) @(posedge clk);
    #1;
    checks++; if (strobeCnt !== 200)    begin errors++; $display("FAIL static_strobes got %0d want 200", strobeCnt); end
    checks++; if (matchCnt !== 0)       begin errors++; $display("FAIL static_matches got %0d want 0", matchCnt); end
    checks++; if (oLock !== 1'b0)       begin errors++; $display("FAIL static_lock got %0b want 0", oLock); end
    checks++; if (oFrames !== 8'd0)     begin errors++; $display("FAIL static_frames got %0d want 0", oFrames); end
    checks++; if (oBit !== 1'b0)        begin errors++; $display("FAIL static_bit0 got %0b want 0", oBit); end
    sig = 1'b1;
    repeat (4 * BIT_CLKS) @(posedge clk);
    #1;
    checks++; if (oBit !== 1'b1)        begin errors++; $display("FAIL static_bit1 got %0b want 1", oBit); end
    checks++; if (matchCnt !== 0)       begin errors++; $display("FAIL static_high_matches got %0d want 0", matchCnt); end
  endtask

  task automatic test_saturation_reset();
    pulseReset();
    test_lock_count();
    for (int n = 0; n < 300; n++) sendFrame(PAT, -1);
    checks++; if (oFrames !== 8'd255)   begin errors++; $display("FAIL sat_frames got %0d want 255", oFrames); end
    checks++; if (oLock !== 1'b1)       begin errors++; $display("FAIL sat_lock got %0b want 1", oLock); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (oLock !== 1'b0)       begin errors++; $display("FAIL midreset_lock got %0b want 0", oLock); end
    checks++; if (oFrames !== 8'd0)     begin errors++; $display("FAIL midreset_frames got %0d want 0", oFrames); end
    checks++; if (oBit !== 1'b0)        begin errors++; $display("FAIL midreset_bit got %0b want 0", oBit); end
    checks++; if ({oBstb, oMatch, oErr} !== 3'b000) begin errors++; $display("FAIL midreset_pulses got %b want 000", {oBstb, oMatch, oErr}); end
    test_lock_count();
  endtask

  initial begin
    test_reset();
    test_lock_count();
    test_single_error();
    test_loss_of_lock();
    test_phase_drift();
    test_static_line();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
